decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   RV32I instruction-decode stage: accepts fetched instructions, drives register-file read
//   addresses, decodes fields/immediates and holds the ID/EX pipeline register for EX.
//   Register-file reads are synchronous (address at edge N -> data valid after edge N), so
//   rs1/rs2 data is aligned with the ID/EX register and passed through to EX unregistered.
//   Detects load-use hazards (one bubble) and honours EX-issued flushes.
// PARAMETERS
//   W  32  data/PC width
//   A  5   register address width
// PORTS
//   clk           in   1   clock, all state on posedge
//   reset         in   1   synchronous, active-high
//   if_valid      in   1   fetch offers an instruction
//   if_ready      out  1   decode accepts this cycle
//   if_instr      in   32  instruction word
//   if_pc         in   W   its PC
//   flush         in   1   EX redirect: kill ID/EX contents and current offer
//   rs1_addr      out  A   register-file read address 1
//   rs2_addr      out  A   register-file read address 2
//   rs1_data      in   W   register-file read data 1
//   rs2_data      in   W   register-file read data 2
//   ex_valid      out  1   ID/EX register holds an instruction
//   ex_ready      in   1   EX consumes this cycle
//   ex_pc, ex_imm out  W   PC; sign-extended immediate (0 for R-type)
//   ex_rs1_val, ex_rs2_val out W  = rs1_data / rs2_data (pass-through)
//   ex_rd, ex_rs1, ex_rs2  out A  register indices; 0 when field unused by format
//   ex_alu_op     out  4   {alt bit, funct3}; 4'b0000 (ADD) for non-ALU ops
//   ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_reg_write, ex_illegal  out 1
// BEHAVIOUR
//   - Reset: ex_valid=0, every ex_* output 0; if_ready follows its equation next cycle.
//   - hazard = ex_valid & ex_is_load & ex_rd!=0 & (incoming rs1 used & ==ex_rd
//     | incoming rs2 used & ==ex_rd); incoming fields from if_instr, only when if_valid.
//   - advance = !ex_valid | ex_ready.
//   - if_ready = flush | (advance & !hazard).  Offer accepted when if_valid & if_ready.
//   - Edge update, priority order: reset > flush (ex_valid<=0, offer dropped) >
//     advance (ex_valid <= if_valid & !hazard; fields load only on acceptance) > hold.
//   - Hazard bubble: ex_valid<=0 while load advances; instruction re-offered next cycle,
//     hazard then clear (ID/EX empty) -> exactly one bubble per load-use pair.
//   - rs1_addr/rs2_addr = (ex_valid & !ex_ready) ? ex_rs1/ex_rs2 : decoded if_instr fields,
//     so held instructions re-read the register file every stall cycle.
//   - Latency: instruction accepted at edge N is on ex_* during cycle N+1, data valid.
//   - Decode (opcode[6:0]): LUI 0110111 U; AUIPC 0010111 U; JAL 1101111 J; JALR 1100111 I;
//     BRANCH 1100011 B; LOAD 0000011 I; STORE 0100011 S; OP-IMM 0010011 I; OP 0110011 R.
//   - reg_write=1 for LUI,AUIPC,JAL,JALR,LOAD,OP-IMM,OP; 0 otherwise; ex_rd=0 when no write.
//   - rs1 used: JALR,BRANCH,LOAD,STORE,OP-IMM,OP. rs2 used: BRANCH,STORE,OP.
//   - alu_op: OP -> {funct7[5],funct3}; OP-IMM -> {funct3==101 & funct7[5], funct3};
//     others 0000.  is_jump for JAL/JALR.
//   - Immediates: I {20{i[31]},i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],i[30:25],
//     i[11:8],0}; U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],0}; all sign-ext to W.
//   - Any other opcode, or i[1:0]!=11: ex_illegal=1, reg_write/load/store/branch/jump=0,
//     rd/rs1/rs2=0; still passes as a valid instruction (EX raises the trap).
//   - Flush with simultaneous hazard or stall: flush wins; if_ready=1, offer discarded.
// TESTING
//   1 reset held 2 cycles, then release with if_valid=0 -> ex_valid=0, all ex_* 0, if_ready=1.
//   2 addi x5,x0,-3 (0xFFD00293), pc=0x100, ex_ready=1 -> next cycle ex_valid=1, ex_rd=5,
//     ex_imm=0xFFFFFFFD, ex_alu_op=0000, ex_reg_write=1, rs1_addr was 0.
//   3 lw x6,0(x1) then add x7,x6,x2 -> one cycle with ex_valid=0 between them, if_ready=0
//     for exactly 1 cycle; add appears with ex_rs1=6, ex_rs2=2, ex_alu_op=0000.
//   4 ex_ready=0 for 3 cycles holding sub x3,x1,x2 -> ex_* stable, if_ready=0,
//     rs1_addr=1, rs2_addr=2 each cycle; ex_alu_op=1000.
//   5 flush=1 with ID/EX full and if_valid=1 -> if_ready=1, next cycle ex_valid=0; offered
//     instruction never appears on ex_*.
//   6 beq x1,x2,-8 (0xFE208CE3) -> ex_imm=0xFFFFFFF8, is_branch=1, reg_write=0, rd=0;
//     word 0xFFFFFFFF -> ex_illegal=1, ex_valid=1.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with ID/EX register and load-use stall
module decode_stage #(
  parameter int W = 32,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_valid,
  output logic         if_ready,
  input  logic [31:0]  if_instr,
  input  logic [W-1:0] if_pc,
  input  logic         flush,
  output logic [A-1:0] rs1_addr,
  output logic [A-1:0] rs2_addr,
  input  logic [W-1:0] rs1_data,
  input  logic [W-1:0] rs2_data,
  output logic         ex_valid,
  input  logic         ex_ready,
  output logic [W-1:0] ex_pc,
  output logic [W-1:0] ex_imm,
  output logic [W-1:0] ex_rs1_val,
  output logic [W-1:0] ex_rs2_val,
  output logic [A-1:0] ex_rd,
  output logic [A-1:0] ex_rs1,
  output logic [A-1:0] ex_rs2,
  output logic [3:0]   ex_alu_op,
  output logic         ex_is_load,
  output logic         ex_is_store,
  output logic         ex_is_branch,
  output logic         ex_is_jump,
  output logic         ex_reg_write,
  output logic         ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0]  i;
  logic [2:0]   f3;
  logic [31:0]  imm32;
  logic [W-1:0] d_imm;
  logic [A-1:0] d_rd, d_rs1, d_rs2;
  logic [3:0]   d_alu_op;
  logic         d_load, d_store, d_branch, d_jump, d_rw, d_illegal;
  logic         use_rs1, use_rs2;
  logic         hazard, advance, accept;

  assign i  = if_instr;
  assign f3 = i[14:12];

  always_comb begin
    imm32     = '0;
    d_alu_op  = 4'b0000;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_rw      = 1'b0;
    d_illegal = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {i[31:12], 12'b0};
        d_rw  = 1'b1;
      end
      OPC_JAL: begin
        imm32  = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        d_rw   = 1'b1;
        d_jump = 1'b1;
      end
      OPC_JALR: begin
        imm32   = {{20{i[31]}}, i[31:20]};
        d_rw    = 1'b1;
        d_jump  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        imm32    = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        d_branch = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OPC_LOAD: begin
        imm32   = {{20{i[31]}}, i[31:20]};
        d_rw    = 1'b1;
        d_load  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        imm32   = {{20{i[31]}}, i[31:25], i[11:7]};
        d_store = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        imm32    = {{20{i[31]}}, i[31:20]};
        d_rw     = 1'b1;
        use_rs1  = 1'b1;
        // only SRAI uses the alt bit; other immediates may have bit 30 set
        d_alu_op = {(f3 == 3'b101) & i[30], f3};
      end
      OPC_OP: begin
        d_rw     = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        d_alu_op = {i[30], f3};
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign d_imm = W'(signed'(imm32));
  assign d_rd  = d_rw    ? i[11:7]  : '0;
  assign d_rs1 = use_rs1 ? i[19:15] : '0;
  assign d_rs2 = use_rs2 ? i[24:20] : '0;

  assign hazard = if_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                  ((use_rs1 & (d_rs1 == ex_rd)) | (use_rs2 & (d_rs2 == ex_rd)));
  assign advance  = !ex_valid | ex_ready;
  assign if_ready = flush | (advance & !hazard);
  assign accept   = advance & if_valid & !hazard;

  // a stalled instruction keeps re-reading its operands so its data stays current
  assign rs1_addr = (ex_valid & !ex_ready) ? ex_rs1 : d_rs1;
  assign rs2_addr = (ex_valid & !ex_ready) ? ex_rs2 : d_rs2;

  assign ex_rs1_val = rs1_data;
  assign ex_rs2_val = rs2_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_alu_op    <= '0;
      ex_is_load   <= 1'b0;
      ex_is_store  <= 1'b0;
      ex_is_branch <= 1'b0;
      ex_is_jump   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      ex_valid <= accept;
      if (accept) begin
        ex_pc        <= if_pc;
        ex_imm       <= d_imm;
        ex_rd        <= d_rd;
        ex_rs1       <= d_rs1;
        ex_rs2       <= d_rs2;
        ex_alu_op    <= d_alu_op;
        ex_is_load   <= d_load;
        ex_is_store  <= d_store;
        ex_is_branch <= d_branch;
        ex_is_jump   <= d_jump;
        ex_reg_write <= d_rw;
        ex_illegal   <= d_illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [3:0]  ex_alu_op;
  logic        ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_reg_write, ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.W(32), .A(5)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_alu_op(ex_alu_op),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    rs1_data = 32'h1111_1111;
    rs2_data = 32'h2222_2222;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
    check("rst_ex_alu_op", {28'b0, ex_alu_op}, 32'd0);
    check("rst_flags", {26'b0, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump,
                        ex_reg_write, ex_illegal}, 32'd0);
    check("rst_if_ready", {31'b0, if_ready}, 32'd1);

    // addi x5,x0,-3
    offer(32'hFFD0_0293, 32'h100);
    check("addi_rs1_addr", {27'b0, rs1_addr}, 32'd0);
    check("addi_if_ready", {31'b0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check("addi_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("addi_ex_rd", {27'b0, ex_rd}, 32'd5);
    check("addi_ex_imm", ex_imm, 32'hFFFF_FFFD);
    check("addi_ex_alu_op", {28'b0, ex_alu_op}, 32'd0);
    check("addi_reg_write", {31'b0, ex_reg_write}, 32'd1);
    check("addi_ex_pc", ex_pc, 32'h100);
    check("addi_rs1_val", ex_rs1_val, 32'h1111_1111);

    // lw x6,0(x1) followed by dependent add x7,x6,x2
    offer(32'h0000_A303, 32'h104);
    check("lw_if_ready", {31'b0, if_ready}, 32'd1);
    tick();
    check("lw_is_load", {31'b0, ex_is_load}, 32'd1);
    check("lw_ex_rd", {27'b0, ex_rd}, 32'd6);
    offer(32'h0023_03B3, 32'h108);
    check("hazard_if_ready", {31'b0, if_ready}, 32'd0);
    tick();
    check("bubble_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("after_bubble_if_ready", {31'b0, if_ready}, 32'd1);
    tick();
    check("add_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("add_ex_rs1", {27'b0, ex_rs1}, 32'd6);
    check("add_ex_rs2", {27'b0, ex_rs2}, 32'd2);
    check("add_ex_rd", {27'b0, ex_rd}, 32'd7);
    check("add_ex_alu_op", {28'b0, ex_alu_op}, 32'd0);
    check("add_ex_pc", ex_pc, 32'h108);

    // sub x3,x1,x2 held for three stall cycles
    offer(32'h4020_81B3, 32'h10C);
    tick();
    ex_ready = 1'b0;
    offer(32'h0010_0493, 32'h110);
    for (int k = 0; k < 3; k++) begin
      check("stall_if_ready", {31'b0, if_ready}, 32'd0);
      check("stall_rs1_addr", {27'b0, rs1_addr}, 32'd1);
      check("stall_rs2_addr", {27'b0, rs2_addr}, 32'd2);
      check("stall_ex_valid", {31'b0, ex_valid}, 32'd1);
      check("stall_ex_alu_op", {28'b0, ex_alu_op}, 32'd8);
      check("stall_ex_rd", {27'b0, ex_rd}, 32'd3);
      check("stall_ex_pc", ex_pc, 32'h10C);
      tick();
    end

    // flush with ID/EX full and an offer pending
    flush = 1'b1;
    #1;
    check("flush_if_ready", {31'b0, if_ready}, 32'd1);
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    check("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
    tick();
    check("flush_dropped", {31'b0, ex_valid}, 32'd0);

    // beq x1,x2,-8
    offer(32'hFE20_8CE3, 32'h200);
    tick();
    if_valid = 1'b0;
    check("beq_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("beq_ex_imm", ex_imm, 32'hFFFF_FFF8);
    check("beq_is_branch", {31'b0, ex_is_branch}, 32'd1);
    check("beq_reg_write", {31'b0, ex_reg_write}, 32'd0);
    check("beq_ex_rd", {27'b0, ex_rd}, 32'd0);
    check("beq_ex_rs2", {27'b0, ex_rs2}, 32'd2);

    // jal x1,+16
    offer(32'h0100_00EF, 32'h204);
    tick();
    check("jal_ex_imm", ex_imm, 32'h10);
    check("jal_is_jump", {31'b0, ex_is_jump}, 32'd1);
    check("jal_ex_rd", {27'b0, ex_rd}, 32'd1);
    check("jal_ex_rs1", {27'b0, ex_rs1}, 32'd0);

    // illegal all-ones word
    offer(32'hFFFF_FFFF, 32'h208);
    tick();
    if_valid = 1'b0;
    check("ill_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("ill_ex_illegal", {31'b0, ex_illegal}, 32'd1);
    check("ill_flags", {27'b0, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump,
                        ex_reg_write}, 32'd0);
    check("ill_regs", {17'b0, ex_rd, ex_rs1, ex_rs2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
